// File: rtl/uart_rx_monitor_if.sv
// Bundle of the serial input and the byte-stream/status outputs of uart_rx_monitor.
// slave: the monitor itself. master: whoever drives the line and consumes bytes.
interface uart_rx_monitor_if #(
    parameter int unsigned FIFO_AW = 4
);
    logic               uart_rx_i;
    logic [7:0]         byte_o;
    logic               byte_valid_o;
    logic               byte_ready_i;
    logic [FIFO_AW:0]   fifo_level_o;
    logic               frame_err_o;
    logic               overflow_o;
    logic               eot_o;

    modport slave (
        input  uart_rx_i,
        input  byte_ready_i,
        output byte_o,
        output byte_valid_o,
        output fifo_level_o,
        output frame_err_o,
        output overflow_o,
        output eot_o
    );

    modport master (
        output uart_rx_i,
        output byte_ready_i,
        input  byte_o,
        input  byte_valid_o,
        input  fifo_level_o,
        input  frame_err_o,
        input  overflow_o,
        input  eot_o
    );
endinterface

// File: rtl/uart_rx_monitor.sv
// UART 8N1 receiver for simulation consoles: oversampled deserialiser feeding a
// first-word-fall-through byte FIFO, with framing-error, overflow and end-of-test flags.
module uart_rx_monitor #(
    parameter int unsigned BAUD_DIV = 868,
    parameter int unsigned FIFO_AW  = 4,
    parameter logic [7:0]  EOT_CHAR = 8'h04
) (
    input logic              wb_clk_i,
    input logic              wb_rst_n_i,
    uart_rx_monitor_if.slave bus
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned CntW  = $clog2(BAUD_DIV);

    localparam logic [CntW-1:0]  HalfLast = CntW'(BAUD_DIV / 2 - 1);
    localparam logic [CntW-1:0]  BitLast  = CntW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] LevelMax = (FIFO_AW + 1)'(Depth);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    // Synchroniser
    logic sync_meta;
    logic rx_s;

    // Deserialiser
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_req;
    logic            frame_err_d;

    // FIFO and status
    logic [7:0]         mem [Depth];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               empty, full, pop, push, drop;
    logic               frame_err_q, overflow_q, eot_q;

    // Two-flop synchroniser; flops reset high so an idle line never looks like a start bit
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= bus.uart_rx_i;
            rx_s      <= sync_meta;
        end
    end

    // FSM state and bit-timing registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next state: start bit checked at mid-bit, data and stop bits one full bit apart
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit gone high again by mid-bit was a glitch
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitIdle: begin
                // Hold off until the line recovers so a long break errors only once
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty = (level == '0);
    assign full  = (level == LevelMax);
    assign pop   = !empty && bus.byte_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    // FIFO storage and pointers; level tracked separately from the wrapping pointers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shift_q;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push && !pop) begin
                level <= level + (FIFO_AW + 1)'(1);
            end else if (pop && !push) begin
                level <= level - (FIFO_AW + 1)'(1);
            end
        end
    end

    // Status flags: frame error pulses, overflow and end-of-test are sticky
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            eot_q       <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            // EOT counts even when the byte itself is dropped for overflow
            if (push_req && shift_q == EOT_CHAR) begin
                eot_q <= 1'b1;
            end
        end
    end

    assign bus.byte_o       = mem[rd_ptr];
    assign bus.byte_valid_o = !empty;
    assign bus.fifo_level_o = level;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.overflow_o   = overflow_q;
    assign bus.eot_o        = eot_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: table of single frames, directed corner
// sequences, and random frames scored against a byte-queue reference model.
module tb_uart_rx_monitor;

    localparam int unsigned BaudDiv = 8;
    localparam int unsigned FifoAw  = 4;
    localparam int unsigned Depth   = 2 ** FifoAw;
    localparam logic [7:0]  EotChar = 8'h04;
    // Frame-relative clock edge of the stop-bit sample: two synchroniser flops,
    // one idle-detect cycle, half a bit to mid start bit, then nine full bits.
    localparam int StopEdge = 3 + BaudDiv / 2 + 9 * BaudDiv;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_monitor_if #(.FIFO_AW(FifoAw)) bus ();

    uart_rx_monitor #(
        .BAUD_DIV(BaudDiv),
        .FIFO_AW (FifoAw),
        .EOT_CHAR(EotChar)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Passive observation away from the active edge
    int         ferr_cnt  = 0;
    int         valid_cyc = 0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (bus.frame_err_o) ferr_cnt++;
        if (bus.byte_valid_o) valid_cyc++;
        if (bus.byte_valid_o && bus.byte_ready_i) got_q.push_back(bus.byte_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // pop_at: frame edge at which a single pop is forced (-1 leaves ready alone,
    // -2 randomises ready every cycle). rst_at: frame cycle with reset low (-1 none).
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int pop_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int c = 0; c < 10 * BaudDiv; c++) begin
            bus.uart_rx_i = bits[c / BaudDiv];
            if (pop_at >= 0) bus.byte_ready_i = (c == pop_at - 1);
            if (pop_at == -2) bus.byte_ready_i = ($urandom_range(0, 1) == 1);
            if (rst_at >= 0) rst_n = (c != rst_at);
            @(posedge clk);
            #1;
        end
        bus.uart_rx_i = 1'b1;
        if (pop_at >= 0) bus.byte_ready_i = 1'b0;
    endtask

    task automatic idle_rand(input int n);
        for (int c = 0; c < n; c++) begin
            bus.byte_ready_i = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         exp_level;
        int         exp_err;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         base, e0, v0, exp_err;
    logic       exp_eot;
    logic [7:0] d;
    logic       good;

    initial begin
        vecs[0] = '{8'h3C, 1'b0, 40, 0, 1};
        vecs[1] = '{8'h00, 1'b1, 0, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0, 1, 0};
        vecs[3] = '{8'h81, 1'b0, 0, 0, 1};
        vecs[4] = '{8'h5A, 1'b1, 0, 1, 0};
        vecs[5] = '{8'h7E, 1'b0, 20, 0, 1};

        bus.uart_rx_i    = 1'b1;
        bus.byte_ready_i = 1'b0;

        // Reset values, both during and after reset
        tick(3);
        check("rst_valid", 32'(bus.byte_valid_o), 0);
        check("rst_level", 32'(bus.fifo_level_o), 0);
        check("rst_byte", 32'(bus.byte_o), 0);
        rst_n = 1'b1;
        tick(3);
        check("rst_ferr", 32'(bus.frame_err_o), 0);
        check("rst_ovf", 32'(bus.overflow_o), 0);
        check("rst_eot", 32'(bus.eot_o), 0);

        // Single byte with consumer always ready
        bus.byte_ready_i = 1'b1;
        base = got_q.size(); v0 = valid_cyc; e0 = ferr_cnt;
        send_frame(8'h55, 1'b1, -1, -1);
        tick(5);
        check("single_count", 32'(got_q.size() - base), 1);
        if (got_q.size() > base) check("single_byte", 32'(got_q[base]), 32'h55);
        check("single_valid_cycles", 32'(valid_cyc - v0), 1);
        check("single_level", 32'(bus.fifo_level_o), 0);
        check("single_ferr", 32'(ferr_cnt - e0), 0);

        // Glitch rejection, then a good frame
        bus.byte_ready_i = 1'b0;
        v0 = valid_cyc; e0 = ferr_cnt;
        bus.uart_rx_i = 1'b0;
        tick(2);
        bus.uart_rx_i = 1'b1;
        tick(3 * BaudDiv);
        check("glitch_valid_cycles", 32'(valid_cyc - v0), 0);
        check("glitch_ferr", 32'(ferr_cnt - e0), 0);
        send_frame(8'hA3, 1'b1, -1, -1);
        tick(2);
        check("glitch_next_level", 32'(bus.fifo_level_o), 1);
        check("glitch_next_byte", 32'(bus.byte_o), 32'hA3);
        bus.byte_ready_i = 1'b1;
        tick(1);
        bus.byte_ready_i = 1'b0;

        // Table of single frames, good and bad stop bits
        for (int i = 0; i < 6; i++) begin
            e0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, -1, -1);
            if (vecs[i].hold > 0) begin
                bus.uart_rx_i = 1'b0;
                tick(vecs[i].hold);
                bus.uart_rx_i = 1'b1;
            end
            tick(2 * BaudDiv);
            check($sformatf("vec%0d_level", i), 32'(bus.fifo_level_o), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_ovf", i), 32'(bus.overflow_o), 0);
            if (vecs[i].exp_level > 0) begin
                check($sformatf("vec%0d_byte", i), 32'(bus.byte_o), 32'(vecs[i].data));
                bus.byte_ready_i = 1'b1;
                tick(1);
                bus.byte_ready_i = 1'b0;
            end
        end

        // Overflow: 17 bytes into a 16-deep FIFO with no consumer
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, -1, -1);
        tick(2);
        check("ovf_level", 32'(bus.fifo_level_o), 32'(Depth));
        check("ovf_flag", 32'(bus.overflow_o), 1);
        check("ovf_head", 32'(bus.byte_o), 0);
        check("ovf_eot", 32'(bus.eot_o), 1);
        base = got_q.size();
        bus.byte_ready_i = 1'b1;
        tick(Depth);
        bus.byte_ready_i = 1'b0;
        check("ovf_drain_count", 32'(got_q.size() - base), 32'(Depth));
        for (int i = 0; i < Depth; i++) begin
            if (base + i < got_q.size()) check($sformatf("ovf_drain%0d", i), 32'(got_q[base + i]), 32'(i));
        end
        check("ovf_drain_level", 32'(bus.fifo_level_o), 0);
        do_reset();
        check("ovf_rst_flag", 32'(bus.overflow_o), 0);
        check("ovf_rst_eot", 32'(bus.eot_o), 0);

        // Full FIFO with a pop on the same edge as the 17th push
        for (int i = 0; i < Depth; i++) send_frame(8'(8'h20 + i), 1'b1, -1, -1);
        base = got_q.size();
        send_frame(8'h30, 1'b1, StopEdge, -1);
        tick(1);
        check("fullpop_ovf", 32'(bus.overflow_o), 0);
        check("fullpop_level", 32'(bus.fifo_level_o), 32'(Depth));
        check("fullpop_popped", 32'(got_q.size() - base), 1);
        if (got_q.size() > base) check("fullpop_first", 32'(got_q[base]), 32'h20);
        bus.byte_ready_i = 1'b1;
        tick(Depth);
        bus.byte_ready_i = 1'b0;
        check("fullpop_drained", 32'(got_q.size() - base), 32'(Depth + 1));
        for (int i = 1; i <= Depth; i++) begin
            if (base + i < got_q.size()) check($sformatf("fullpop_drain%0d", i), 32'(got_q[base + i]), 32'(8'h20 + i));
        end

        // End-of-test character, then reset in the stop bit of a later frame
        send_frame(8'h41, 1'b1, -1, -1);
        check("eot_before", 32'(bus.eot_o), 0);
        send_frame(EotChar, 1'b1, -1, -1);
        check("eot_set", 32'(bus.eot_o), 1);
        check("eot_level", 32'(bus.fifo_level_o), 2);
        check("eot_head", 32'(bus.byte_o), 32'h41);
        e0 = ferr_cnt;
        send_frame(8'h42, 1'b1, -1, 9 * BaudDiv + 1);
        rst_n = 1'b1;
        check("midrst_level", 32'(bus.fifo_level_o), 0);
        check("midrst_valid", 32'(bus.byte_valid_o), 0);
        check("midrst_eot", 32'(bus.eot_o), 0);
        check("midrst_byte", 32'(bus.byte_o), 0);
        tick(3 * BaudDiv);
        check("midrst_after_level", 32'(bus.fifo_level_o), 0);
        check("midrst_after_ferr", 32'(ferr_cnt - e0), 0);

        // Random frames against a queue model of delivered bytes
        base = got_q.size(); e0 = ferr_cnt;
        exp_err = 0; exp_eot = 1'b0;
        for (int f = 0; f < 40; f++) begin
            d    = 8'($urandom);
            if ($urandom_range(0, 9) == 0) d = EotChar;
            good = ($urandom_range(0, 7) != 0);
            if (good) begin
                exp_q.push_back(d);
                if (d == EotChar) exp_eot = 1'b1;
            end else begin
                exp_err++;
            end
            send_frame(d, good, -2, -1);
            idle_rand($urandom_range(2, BaudDiv));
        end
        bus.byte_ready_i = 1'b1;
        tick(2 * Depth);
        bus.byte_ready_i = 1'b0;
        check("rand_count", 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) check($sformatf("rand_byte%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));
        end
        check("rand_ferr", 32'(ferr_cnt - e0), 32'(exp_err));
        check("rand_eot", 32'(bus.eot_o), 32'(exp_eot));
        check("rand_ovf", 32'(bus.overflow_o), 0);
        check("rand_level", 32'(bus.fifo_level_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Simulation-side consumer of the SoC UART transmit pad.
- Oversamples the serial line and deserialises 8N1 frames, LSB first.
- Buffers received bytes in a first-word-fall-through FIFO for the bench console/logger.
- Flags framing errors, FIFO overflow and an end-of-test character so the bench can terminate the run on a program's exit marker.

Parameters:
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 4.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.
- EOT_CHAR, 8'h04, byte value that sets eot_o.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  reset, synchronous, active-low.
- uart_rx_i  in  1  serial line driven by the SoC UART TX; idle high.
- byte_o  out  8  FIFO head byte.
- byte_valid_o  out  1  FIFO non-empty; byte_o is valid.
- byte_ready_i  in  1  consumer pops the head when byte_valid_o & byte_ready_i.
- fifo_level_o  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
- frame_err_o  out  1  one-cycle pulse on a bad stop bit.
- overflow_o  out  1  sticky; a byte was dropped because the FIFO was full.
- eot_o  out  1  sticky; EOT_CHAR was received with a good stop bit.

Behaviour:
- Clock and reset: single clock domain (wb_clk_i); reset is synchronous and active-low (wb_rst_n_i).
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, bit counter 0.
- Synchroniser: uart_rx_i passes through a 2-flop synchroniser whose flops reset to 1 (no false start out of reset). Only the synchronised signal, rx_s, is used downstream.
- FSM state IDLE: when rx_s == 0 -> START, baud counter cleared.
- FSM state START: at counter == BAUD_DIV/2 - 1, sample rx_s.
  - Low -> DATA, counter cleared, bit index 0.
  - High -> glitch; return to IDLE with no output.
- FSM state DATA: at counter == BAUD_DIV - 1, sample rx_s into shift bit[index] (LSB first) and clear the counter. After bit 7 -> STOP.
- FSM state STOP: at counter == BAUD_DIV - 1, sample rx_s.
  - High -> push the byte, return to IDLE.
  - Low -> pulse frame_err_o for 1 cycle, discard the byte, go to WAIT_IDLE.
- FSM state WAIT_IDLE: remain until rx_s == 1, then -> IDLE. A held-low break therefore produces exactly one frame_err_o pulse.
- Push rules:
  - Latency: the byte is visible on byte_o/byte_valid_o in the cycle after the stop-bit sample, when the FIFO was empty.
  - Full and no pop in the same cycle: drop the new byte, set overflow_o. FIFO contents are unchanged.
  - Full with a pop in the same cycle: the push is accepted and the level stays at max.
  - Empty with a push in the same cycle: byte_valid_o rises the next cycle. A pop while empty is ignored.
- eot_o is set when a good-stop byte equals EOT_CHAR, even if that byte is dropped for overflow. A byte equal to EOT_CHAR is still pushed like any other byte.
- FIFO: circular buffer with FIFO_AW-bit read/write pointers that wrap modulo depth. The level counter is incremented/decremented independently of the pointers. byte_o is combinational from mem[rd_ptr].
- Reset mid-frame: the partial byte is lost, the FSM returns to IDLE, the FIFO is emptied and the sticky flags are cleared. A line held low at reset release starts a frame only after the synchroniser outputs 0, i.e. 2 cycles after reset release.
- Timing tolerance: a mid-bit sample point tolerates ±40% of BAUD_DIV/2 of accumulated drift over a frame.

Test Plan:
- Single byte: BAUD_DIV=8, drive 0x55 frame, byte_ready_i=1 -> byte_o=0x55, byte_valid_o high 1 cycle, fifo_level_o returns to 0, frame_err_o never asserted.
- Glitch rejection: BAUD_DIV=8, pulse uart_rx_i low for 2 cycles -> FSM back to IDLE, byte_valid_o stays 0, no frame_err_o. A following 0xA3 frame is received correctly.
- Framing error: 0x3C frame with stop bit low, line held low 40 cycles, then idle -> exactly one frame_err_o pulse, fifo_level_o stays 0.
- Overflow: FIFO_AW=4, byte_ready_i=0, send 17 bytes 0x00..0x10 -> fifo_level_o=16, overflow_o=1, byte_o=0x00. Popping all 16 yields 0x00..0x0F in order.
- Full plus simultaneous pop: FIFO full; pop asserted in the same cycle as the 17th stop-bit push -> overflow_o stays 0, level stays 16, last byte read = the 17th byte.
- EOT and reset: send 0x41 then 0x04 -> eot_o=1 after the second stop sample, both bytes in the FIFO. Then assert wb_rst_n_i=0 for 1 cycle mid-frame of 0x42 -> all outputs 0, the remaining frame bits produce no byte.
